// File: rtl/pixel_readout_pkg.sv
// Shared types and defaults for the pixel hit counter and its serial readout chain.
package pixel_readout_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_LOW = 2'd1,
    COUNTING = 2'd2
  } cnt_state_t;

  // Plain-vector views of the state encodings for logic that carries the raw 2-bit state.
  localparam logic [1:0] ST_IDLE     = IDLE;
  localparam logic [1:0] ST_WAIT_LOW = WAIT_LOW;
  localparam logic [1:0] ST_COUNTING = COUNTING;

  localparam int unsigned DEFAULT_COUNT_WIDTH = 12;
  localparam int unsigned DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/hit_sync_edge.sv
// Multi-flop synchroniser for the arbiter winner level followed by a rising-edge detector.
module hit_sync_edge
  import pixel_readout_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic rstn,
  input  logic asyncIn,
  output logic syncLevel,
  output logic risePulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   history;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q  <= '0;
      history <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], asyncIn};
      history <= sync_q[SYNC_STAGES-1];
    end
  end

  assign syncLevel = sync_q[SYNC_STAGES-1];
  assign risePulse = syncLevel & ~history;

endmodule

// File: rtl/pixel_hit_counter.sv
// Per-pixel photon counter with latch-and-restart shadow register on the column serial chain.
// Build option: define COUNT_SATURATE_EN to make the counter stick at all-ones instead of wrapping.
module pixel_hit_counter
  import pixel_readout_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH = DEFAULT_COUNT_WIDTH,
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   winerAll,
  input  logic                   shutter,
  input  logic                   latchCount,
  input  logic                   shiftEnable,
  input  logic                   serialIn,
  output logic                   serialOut,
  output logic [COUNT_WIDTH-1:0] countValue,
  output logic                   hitPulse,
  output logic [1:0]             counterState
);

  logic                   synced;
  logic                   hit;
  logic [1:0]             state;
  logic [1:0]             state_next;
  logic [COUNT_WIDTH-1:0] count;
  logic [COUNT_WIDTH-1:0] count_inc;
  logic [COUNT_WIDTH-1:0] shadow;
  logic                   countable;

  hit_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rstn     (rstn),
    .asyncIn  (winerAll),
    .syncLevel(synced),
    .risePulse(hit)
  );

  // A level already high when the shutter opens must fall before counting starts.
  always_comb begin
    state_next = ST_IDLE;
    case (state)
      ST_IDLE:     state_next = !shutter ? ST_IDLE : (synced ? ST_WAIT_LOW : ST_COUNTING);
      ST_WAIT_LOW: state_next = !shutter ? ST_IDLE : (synced ? ST_WAIT_LOW : ST_COUNTING);
      ST_COUNTING: state_next = shutter ? ST_COUNTING : ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  assign countable = (state == ST_COUNTING) && hit;

  always_comb begin
`ifdef COUNT_SATURATE_EN
    count_inc = (&count) ? count : count + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
`else
    count_inc = count + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= ST_IDLE;
      count  <= '0;
      shadow <= '0;
    end else begin
      state <= state_next;
      // Restarting at 1 keeps a hit that coincides with the snapshot.
      if (latchCount) begin
        count  <= {{(COUNT_WIDTH-1){1'b0}}, countable};
        shadow <= count;
      end else begin
        if (countable)
          count <= count_inc;
        if (shiftEnable)
          shadow <= {shadow[COUNT_WIDTH-2:0], serialIn};
      end
    end
  end

  assign serialOut    = shadow[COUNT_WIDTH-1];
  assign countValue   = count;
  assign hitPulse     = hit;
  assign counterState = state;

endmodule
